word_packer: RTL and testbench
==============================

WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 The block SHALL be configured by parameter WIDTH, default 8, giving bits per serial word.
REQ-002 The block SHALL be configured by parameter K, default 4, giving words per packed group; it equals the downstream buffer's parallel-input count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  WIDTH  serial word from the producer.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  the block accepts a word this cycle.
REQ-008 buf_ready  input  1  the downstream buffer can take one K-word group this cycle.
REQ-009 w_en  output  1  registered write strobe to the downstream buffer.
REQ-010 par_out  output  WIDTH*K  packed group to the downstream buffer par_in.
REQ-011 level  output  clog2(K+1)  number of words currently held, 0..K.

Function
REQ-012 The block SHALL implement a two-state machine, FILL and HOLD.
REQ-013 In FILL, in_ready SHALL be 1; in HOLD, in_ready SHALL be 0; in_ready is combinational from state only.
REQ-014 A word SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-015 The n-th accepted word of a group (n = 0..K-1) SHALL be written to par_out[WIDTH*n +: WIDTH], so word 0 is in the LSB slice.
REQ-016 level SHALL increment by 1 per accepted word and SHALL equal the slot index of the next word.
REQ-017 When the K-th word is accepted, the state SHALL move to HOLD and w_en SHALL be 1 from the next cycle.
REQ-018 In HOLD, w_en and par_out SHALL stay stable until a rising edge with buf_ready = 1; that edge completes the transfer.
REQ-019 On transfer, the block SHALL set state to FILL, w_en to 0 and level to 0; par_out SHALL retain its value until overwritten slice by slice.
REQ-020 Minimum group period SHALL be K+1 cycles: K accept cycles plus one HOLD cycle; one in_ready bubble per group is required.
REQ-021 in_valid with in_ready = 0 SHALL NOT change any state; the producer holds in_data.
REQ-022 buf_ready in FILL SHALL be ignored.
REQ-023 w_en SHALL never be 1 in FILL and SHALL never drop in HOLD before a transfer.

Reset
REQ-024 While rst = 0, the block SHALL hold state FILL, w_en 0, par_out all zeros and level 0, independent of clk.
REQ-025 Reset asserted mid-group or in HOLD SHALL discard the partial or pending group; no write is issued for it.
REQ-026 After rst deasserts, the first accepted word SHALL go to slot 0.

Configuration
REQ-027 With macro WORD_PACKER_FLUSH_EN defined, the block SHALL add input port flush (1 bit, sampled on clk).
REQ-028 Flush behaviour, FILL with level > 0: slots level..K-1 of par_out SHALL be zeroed, the state SHALL move to HOLD, and the write SHALL follow REQ-018.
REQ-029 Flush with level = 0, or in HOLD, SHALL be ignored.
REQ-030 Flush in the same cycle as an accept SHALL first store the word, then:
- if that word completes the group, normal HOLD entry applies and the flush is consumed;
- otherwise the padded group is flushed.
REQ-031 Without WORD_PACKER_FLUSH_EN, the flush port SHALL NOT exist, and partial groups SHALL remain held until completed or reset.

Verification
REQ-032 The bench SHALL cover: K=4, WIDTH=8, buf_ready=1; words 0x0C,0x19,0x0F,0x0A on consecutive cycles -> w_en=1 for exactly one cycle starting the cycle after the 4th accept, with par_out=0x0A0F190C.
REQ-033 The bench SHALL cover: same group with buf_ready=0 for 5 cycles after HOLD entry -> w_en and par_out stable for 5 cycles, in_ready=0, in_valid ignored; then buf_ready=1 -> a single transfer, then FILL.
REQ-034 The bench SHALL cover: in_valid toggling 1,0,1,0 ... -> level steps only on accepted cycles, with final par_out correct and in order.
REQ-035 The bench SHALL cover: rst pulled low after 2 accepts (async, mid-cycle) -> par_out=0, level=0, w_en=0 immediately; the next group starts at slot 0.
REQ-036 The bench SHALL cover: with WORD_PACKER_FLUSH_EN, words 0xAA,0xBB then flush -> par_out=0x0000BBAA, w_en=1 the next cycle; flush at level 0 -> no w_en.
REQ-037 The bench SHALL cover: continuous in_valid=1, buf_ready=1 for 3 groups -> 3 w_en pulses spaced 5 cycles apart, with no word lost or duplicated.

Source files
------------

// File: rtl/word_packer.sv
// Serial-to-parallel packer: gathers K words of WIDTH bits into one group write.
// Optional macro WORD_PACKER_FLUSH_EN adds a flush input that pads and emits a partial group.
module word_packer #(
    parameter int WIDTH = 8,
    parameter int K     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     buf_ready,
`ifdef WORD_PACKER_FLUSH_EN
    input  logic                     flush,
`endif
    output logic                     w_en,
    output logic [WIDTH*K-1:0]       par_out,
    output logic [$clog2(K+1)-1:0]   level
);

    localparam int LW = $clog2(K+1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 w_en_q, w_en_d;
    logic [WIDTH*K-1:0]   par_q, par_d;
    logic [LW-1:0]        level_q, level_d;
    logic [LW-1:0]        cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            w_en_q  <= 1'b0;
            par_q   <= '0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            w_en_q  <= w_en_d;
            par_q   <= par_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d = state_q;
        w_en_d  = w_en_q;
        par_d   = par_q;
        level_d = level_q;
        cnt     = level_q;
        unique case (state_q)
            FILL: begin
                if (in_valid) begin
                    for (int i = 0; i < K; i++) begin
                        if (LW'(i) == level_q)
                            par_d[WIDTH*i +: WIDTH] = in_data;
                    end
                    cnt = level_q + 1'b1;
                end
                level_d = cnt;
                if (cnt == LW'(K)) begin
                    state_d = HOLD;
                    w_en_d  = 1'b1;
                end
`ifdef WORD_PACKER_FLUSH_EN
                // A flush that coincides with the completing word is absorbed
                else if (flush && cnt != '0) begin
                    for (int i = 0; i < K; i++) begin
                        if (LW'(i) >= cnt)
                            par_d[WIDTH*i +: WIDTH] = '0;
                    end
                    state_d = HOLD;
                    w_en_d  = 1'b1;
                end
`endif
            end
            HOLD: begin
                if (buf_ready) begin
                    state_d = FILL;
                    w_en_d  = 1'b0;
                    level_d = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    assign in_ready = (state_q == FILL);
    assign w_en     = w_en_q;
    assign par_out  = par_q;
    assign level    = level_q;

endmodule

// File: tb/tb_word_packer.sv
// Self-checking bench for word_packer: directed scenarios plus random traffic
// compared against a queue-based model of held words and completed groups.
module tb_word_packer;

    localparam int WIDTH = 8;
    localparam int K     = 4;
    localparam int LW    = $clog2(K+1);
`ifdef WORD_PACKER_FLUSH_EN
    localparam bit FLUSH_ON = 1'b1;
`else
    localparam bit FLUSH_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [WIDTH-1:0]     in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 buf_ready;
    logic                 flush;
    logic                 w_en;
    logic [WIDTH*K-1:0]   par_out;
    logic [LW-1:0]        level;

    word_packer #(.WIDTH(WIDTH), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .buf_ready (buf_ready),
`ifdef WORD_PACKER_FLUSH_EN
        .flush     (flush),
`endif
        .w_en      (w_en),
        .par_out   (par_out),
        .level     (level)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc_n = 0;

    logic [WIDTH-1:0]   held[$];
    bit                 pend = 0;
    logic [WIDTH*K-1:0] mdl_x[$];
    logic [WIDTH*K-1:0] dut_x[$];
    int                 pulses[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH*K-1:0] pack(input int n);
        logic [WIDTH*K-1:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[WIDTH*i +: WIDTH] = held[i];
        return r;
    endfunction

    function automatic logic [WIDTH*K-1:0] mask(input int n);
        logic [WIDTH*K-1:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[WIDTH*i +: WIDTH] = '1;
        return r;
    endfunction

    task automatic check_model();
        int n;
        n = held.size();
        chk("in_ready", 64'(in_ready), 64'(!pend));
        chk("w_en", 64'(w_en), 64'(pend));
        chk("level", 64'(level), 64'(n));
        if (pend) chk("par_hold", 64'(par_out), 64'(pack(n)));
        else chk("par_fill", 64'(par_out & mask(n)), 64'(pack(n)));
    endtask

    // Called at a falling edge; ends at the next falling edge after checking.
    task automatic cyc(input bit v, input logic [WIDTH-1:0] d,
                       input bit br, input bit fl);
        in_valid = v;
        in_data = d;
        buf_ready = br;
        flush = fl;
        if (w_en === 1'b1 && br) dut_x.push_back(par_out);
        @(posedge clk);
        if (!pend) begin
            if (v) held.push_back(d);
            if (held.size() == K) pend = 1;
            else if (fl && FLUSH_ON && held.size() > 0) pend = 1;
        end else if (br) begin
            mdl_x.push_back(pack(held.size()));
            pend = 0;
            held.delete();
        end
        @(negedge clk);
        cyc_n++;
        check_model();
    endtask

    task automatic async_reset();
        in_valid = 0;
        flush = 0;
        #3 rst = 0;
        #1;
        chk("rst_par", 64'(par_out), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_wen", 64'(w_en), 64'(0));
        chk("rst_ready", 64'(in_ready), 64'(1));
        held.delete();
        pend = 0;
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        logic [WIDTH-1:0] g1[4];
        logic [WIDTH-1:0] stream[$];
        int idx;
        g1[0] = 8'h0C; g1[1] = 8'h19; g1[2] = 8'h0F; g1[3] = 8'h0A;

        rst = 0;
        in_valid = 0; in_data = '0; buf_ready = 0; flush = 0;
        #7;
        chk("init_par", 64'(par_out), 64'(0));
        chk("init_wen", 64'(w_en), 64'(0));
        chk("init_level", 64'(level), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        check_model();

        // Back-to-back group with the buffer always ready
        for (int i = 0; i < 4; i++) cyc(1, g1[i], 1, 0);
        chk("g1_wen", 64'(w_en), 64'(1));
        chk("g1_par", 64'(par_out), 64'(32'h0A0F190C));
        cyc(0, '0, 1, 0);
        chk("g1_wen_drop", 64'(w_en), 64'(0));

        // Buffer stalls for 5 cycles while the producer keeps pushing
        for (int i = 0; i < 4; i++) cyc(1, g1[i], 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 8'hEE, 0, 0);
            chk("stall_par", 64'(par_out), 64'(32'h0A0F190C));
        end
        cyc(1, 8'hEE, 1, 0);
        chk("stall_done_ready", 64'(in_ready), 64'(1));

        // Gapped valid
        for (int i = 0; i < 8; i++) cyc(i % 2 == 0, 8'h30 + 8'(i), 1, 0);
        chk("gap_par", 64'(par_out), 64'(32'h36343230));
        cyc(0, '0, 1, 0);

        // Async reset after two accepts, then a fresh group
        cyc(1, 8'h11, 1, 0);
        cyc(1, 8'h22, 1, 0);
        async_reset();
        for (int i = 0; i < 4; i++) cyc(1, 8'h40 + 8'(i), 1, 0);
        chk("post_rst_par", 64'(par_out), 64'(32'h43424140));
        cyc(0, '0, 1, 0);

`ifdef WORD_PACKER_FLUSH_EN
        cyc(1, 8'hAA, 1, 0);
        cyc(1, 8'hBB, 1, 0);
        cyc(0, '0, 0, 1);
        chk("flush_par", 64'(par_out), 64'(32'h0000BBAA));
        chk("flush_wen", 64'(w_en), 64'(1));
        cyc(0, '0, 1, 0);
        cyc(0, '0, 1, 1);
        chk("flush_empty_wen", 64'(w_en), 64'(0));
`endif

        // Continuous stream: three groups, pulses five cycles apart
        for (int i = 0; i < 12; i++) stream.push_back(8'($urandom));
        idx = 0;
        pulses.delete();
        for (int c = 0; c < 15; c++) begin
            bit acc;
            acc = !pend && idx < 12;
            cyc(idx < 12, stream[idx < 12 ? idx : 0], 1, 0);
            if (acc) idx++;
            if (w_en === 1'b1) pulses.push_back(cyc_n);
        end
        chk("cont_words", 64'(idx), 64'(12));
        chk("cont_pulses", 64'(pulses.size()), 64'(3));
        for (int i = 1; i < pulses.size(); i++)
            chk("cont_spacing", 64'(pulses[i] - pulses[i-1]), 64'(5));
        cyc(0, '0, 1, 0);

        // Random traffic
        for (int c = 0; c < 300; c++)
            cyc($urandom_range(0, 3) != 0, 8'($urandom),
                $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
        for (int c = 0; c < 3; c++) cyc(0, '0, 1, 0);

        chk("xfer_count", 64'(dut_x.size()), 64'(mdl_x.size()));
        for (int i = 0; i < dut_x.size() && i < mdl_x.size(); i++)
            chk("xfer_data", 64'(dut_x[i]), 64'(mdl_x[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
